wb_slave_mux: RTL and testbench

//   Single-master to NUM_SLAVES Wishbone classic decoder with bus watchdog. Sits between the
//   bus bridge master and the register slaves (system block, user cores). It decodes the

---
 rtl/wb_slave_mux.sv | 224 ++++++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mux.sv
// Single-master Wishbone classic decoder for NUM_SLAVES register slaves.
// Decodes a select field of the address, forwards one registered transaction
// at a time and turns unmapped accesses, slave errors and stalled slaves into
// an err response so the master can never hang.
module wb_slave_mux #(
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned SEL_LO     = 16,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   // master side
   input  logic                     wbm_cyc_i,
   input  logic                     wbm_stb_i,
   input  logic                     wbm_we_i,
   input  logic [3:0]               wbm_sel_i,
   input  logic [31:0]              wbm_adr_i,
   input  logic [31:0]              wbm_dat_i,
   output logic [31:0]              wbm_dat_o,
   output logic                     wbm_ack_o,
   output logic                     wbm_err_o,
   // slave side
   output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]    wbs_stb_o,
   output logic                     wbs_we_o,
   output logic [3:0]               wbs_sel_o,
   output logic [31:0]              wbs_adr_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [32*NUM_SLAVES-1:0] wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
   input  logic [NUM_SLAVES-1:0]    wbs_err_i,
   // status
   output logic                     timeout_o,
   output logic [7:0]               err_count_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [SEL_W:0]   SLV_LIMIT  = (SEL_W + 1)'(NUM_SLAVES);
   localparam logic [7:0]       CNT_MAX    = 8'hFF;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [SEL_W-1:0]      slv_q;
   logic [SEL_W-1:0]      slv_d;
   logic [TW-1:0]         timer_q;
   logic [TW-1:0]         timer_d;

   logic [NUM_SLAVES-1:0] cyc_d;
   logic [NUM_SLAVES-1:0] stb_d;
   logic                  we_d;
   logic [3:0]            sel_d;
   logic [31:0]           adr_d;
   logic [31:0]           dat_d;
   logic [31:0]           mdat_d;
   logic                  ack_d;
   logic                  err_d;
   logic                  timeout_d;
   logic [7:0]            cnt_d;

   logic [SEL_W-1:0]      req_slv_c;
   logic                  req_mapped_c;
   logic [NUM_SLAVES-1:0] req_onehot_c;
   logic                  slv_ack_c;
   logic                  slv_err_c;
   logic [DW-1:0]         slv_dat_c;

   // Decode the select field of the incoming master address
   always_comb begin
      req_slv_c    = wbm_adr_i[SEL_LO +: SEL_W];
      req_mapped_c = ({1'b0, req_slv_c} < SLV_LIMIT);
      req_onehot_c = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (req_slv_c == SEL_W'(k)) begin
            req_onehot_c[k] = 1'b1;
         end
      end
   end

   // Pick the response of the latched slave only; everyone else is ignored
   always_comb begin
      slv_ack_c = 1'b0;
      slv_err_c = 1'b0;
      slv_dat_c = '0;
      for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
         if (slv_q == SEL_W'(k)) begin
            slv_ack_c = wbs_ack_i[k];
            slv_err_c = wbs_err_i[k];
            slv_dat_c = wbs_dat_i[DW*k +: DW];
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      slv_d     = slv_q;
      timer_d   = timer_q;
      cyc_d     = wbs_cyc_o;
      stb_d     = wbs_stb_o;
      we_d      = wbs_we_o;
      sel_d     = wbs_sel_o;
      adr_d     = wbs_adr_o;
      dat_d     = wbs_dat_o;
      mdat_d    = '0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      cnt_d     = err_count_o;

      case (state_q)
         IDLE: begin
            cyc_d = '0;
            stb_d = '0;
            if (wbm_cyc_i && wbm_stb_i) begin
               adr_d   = wbm_adr_i;
               dat_d   = wbm_dat_i;
               sel_d   = wbm_sel_i;
               we_d    = wbm_we_i;
               slv_d   = req_slv_c;
               timer_d = '0;
               if (req_mapped_c) begin
                  state_d = ACTIVE;
                  cyc_d   = req_onehot_c;
                  stb_d   = req_onehot_c;
               end else begin
                  // unmapped window: answer directly, no slave is touched
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end

         ACTIVE: begin
            if (!wbm_cyc_i) begin
               // master walked away: silently release the slave
               state_d = IDLE;
               cyc_d   = '0;
               stb_d   = '0;
            end else if (slv_err_c) begin
               state_d = RESP;
               cyc_d   = '0;
               stb_d   = '0;
               err_d   = 1'b1;
            end else if (slv_ack_c) begin
               state_d = RESP;
               cyc_d   = '0;
               stb_d   = '0;
               ack_d   = 1'b1;
               mdat_d  = wbs_we_o ? '0 : slv_dat_c;
            end else if (timer_q == TIMER_LAST) begin
               state_d   = RESP;
               cyc_d     = '0;
               stb_d     = '0;
               err_d     = 1'b1;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         RESP: begin
            // ack/err was raised on entry; one cycle and done
            state_d = IDLE;
            cyc_d   = '0;
            stb_d   = '0;
         end

         default: begin
            state_d = IDLE;
            cyc_d   = '0;
            stb_d   = '0;
         end
      endcase

      // count every err response, saturating
      if (err_d && (err_count_o != CNT_MAX)) begin
         cnt_d = err_count_o + 8'd1;
      end
   end

   // State and registered outputs
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         slv_q       <= '0;
         timer_q     <= '0;
         wbs_cyc_o   <= '0;
         wbs_stb_o   <= '0;
         wbs_we_o    <= 1'b0;
         wbs_sel_o   <= '0;
         wbs_adr_o   <= '0;
         wbs_dat_o   <= '0;
         wbm_dat_o   <= '0;
         wbm_ack_o   <= 1'b0;
         wbm_err_o   <= 1'b0;
         timeout_o   <= 1'b0;
         err_count_o <= '0;
      end else begin
         state_q     <= state_d;
         slv_q       <= slv_d;
         timer_q     <= timer_d;
         wbs_cyc_o   <= cyc_d;
         wbs_stb_o   <= stb_d;
         wbs_we_o    <= we_d;
         wbs_sel_o   <= sel_d;
         wbs_adr_o   <= adr_d;
         wbs_dat_o   <= dat_d;
         wbm_dat_o   <= mdat_d;
         wbm_ack_o   <= ack_d;
         wbm_err_o   <= err_d;
         timeout_o   <= timeout_d;
         err_count_o <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: three slaves, 16-cycle watchdog.
module tb_wb_slave_mux;

   localparam int unsigned NS = 3;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i = 1'b1;
   logic          wbm_cyc_i = 1'b0;
   logic          wbm_stb_i = 1'b0;
   logic          wbm_we_i = 1'b0;
   logic [3:0]    wbm_sel_i = '0;
   logic [31:0]   wbm_adr_i = '0;
   logic [31:0]   wbm_dat_i = '0;
   logic [31:0]   wbm_dat_o;
   logic          wbm_ack_o;
   logic          wbm_err_o;
   logic [NS-1:0] wbs_cyc_o;
   logic [NS-1:0] wbs_stb_o;
   logic          wbs_we_o;
   logic [3:0]    wbs_sel_o;
   logic [31:0]   wbs_adr_o;
   logic [31:0]   wbs_dat_o;
   logic [32*NS-1:0] wbs_dat_i = '0;
   logic [NS-1:0] wbs_ack_i = '0;
   logic [NS-1:0] wbs_err_i = '0;
   logic          timeout_o;
   logic [7:0]    err_count_o;

   int n_checks = 0;
   int n_errors = 0;

   wb_slave_mux #(
      .NUM_SLAVES (NS),
      .SEL_LO     (16),
      .SEL_W      (2),
      .TIMEOUT    (16)
   ) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .wbm_cyc_i   (wbm_cyc_i),
      .wbm_stb_i   (wbm_stb_i),
      .wbm_we_i    (wbm_we_i),
      .wbm_sel_i   (wbm_sel_i),
      .wbm_adr_i   (wbm_adr_i),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_ack_o   (wbm_ack_o),
      .wbm_err_o   (wbm_err_o),
      .wbs_cyc_o   (wbs_cyc_o),
      .wbs_stb_o   (wbs_stb_o),
      .wbs_we_o    (wbs_we_o),
      .wbs_sel_o   (wbs_sel_o),
      .wbs_adr_o   (wbs_adr_o),
      .wbs_dat_o   (wbs_dat_o),
      .wbs_dat_i   (wbs_dat_i),
      .wbs_ack_i   (wbs_ack_i),
      .wbs_err_i   (wbs_err_i),
      .timeout_o   (timeout_o),
      .err_count_o (err_count_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // hard stop in case anything deadlocks
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // outputs are sampled and inputs changed on the falling edge
   task automatic tick();
      @(negedge wb_clk_i);
   endtask

   task automatic master_req(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat, input logic [3:0] sel);
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      wbm_adr_i = adr;
      wbm_we_i  = we;
      wbm_dat_i = dat;
      wbm_sel_i = sel;
   endtask

   task automatic master_idle();
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
   endtask

   initial begin
      int stb_cycles;
      int to_pulses;
      int err_cycles;
      int ack_cycles;
      int err_seen;

      // ---------------- reset ----------------
      tick();
      tick();
      check("rst_ack", 32'(wbm_ack_o), 32'd0);
      check("rst_err", 32'(wbm_err_o), 32'd0);
      check("rst_stb", 32'(wbs_stb_o), 32'd0);
      check("rst_cyc", 32'(wbs_cyc_o), 32'd0);
      check("rst_adr", wbs_adr_o, 32'd0);
      check("rst_cnt", 32'(err_count_o), 32'd0);
      wb_rst_i = 1'b0;
      tick();

      // ---------------- 1: read slave 1, registered slave ----------------
      master_req(32'h0001_0008, 1'b0, 32'h0, 4'hF);
      tick();
      check("t1_stb_a", 32'(wbs_stb_o), 32'b010);
      check("t1_cyc_a", 32'(wbs_cyc_o), 32'b010);
      check("t1_adr", wbs_adr_o, 32'h0001_0008);
      tick();
      check("t1_stb_b", 32'(wbs_stb_o), 32'b010);
      check("t1_noack", 32'(wbm_ack_o), 32'd0);
      wbs_ack_i = 3'b010;
      wbs_dat_i[63:32] = 32'hDEAD_BEEF;
      tick();
      check("t1_ack", 32'(wbm_ack_o), 32'd1);
      check("t1_err", 32'(wbm_err_o), 32'd0);
      check("t1_dat", wbm_dat_o, 32'hDEAD_BEEF);
      check("t1_stb_off", 32'(wbs_stb_o), 32'd0);
      master_idle();
      // trailing ack from a registered slave stays up for the RESP cycle
      tick();
      check("t1_ack_one", 32'(wbm_ack_o), 32'd0);
      check("t1_dat_clr", wbm_dat_o, 32'd0);
      check("t1_stb_idle", 32'(wbs_stb_o), 32'd0);
      wbs_ack_i = '0;
      wbs_dat_i = '0;
      tick();
      check("t1_no_extra", 32'(wbm_ack_o), 32'd0);

      // ---------------- 2: write slave 0, master bus changes mid-flight ----------------
      master_req(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011);
      tick();
      wbm_adr_i = 32'hFFFF_FFFF;
      wbm_dat_i = 32'hA5A5_A5A5;
      wbm_sel_i = 4'b1100;
      wbm_we_i  = 1'b0;
      check("t2_stb", 32'(wbs_stb_o), 32'b001);
      check("t2_dat_a", wbs_dat_o, 32'h1234_5678);
      check("t2_sel_a", 32'(wbs_sel_o), 32'h3);
      check("t2_we_a", 32'(wbs_we_o), 32'd1);
      tick();
      check("t2_dat_b", wbs_dat_o, 32'h1234_5678);
      check("t2_sel_b", 32'(wbs_sel_o), 32'h3);
      check("t2_we_b", 32'(wbs_we_o), 32'd1);
      check("t2_adr_b", wbs_adr_o, 32'h0000_0010);
      wbs_ack_i = 3'b001;
      wbs_dat_i[31:0] = 32'hFFFF_FFFF;
      tick();
      check("t2_ack", 32'(wbm_ack_o), 32'd1);
      check("t2_dat", wbm_dat_o, 32'd0);
      master_idle();
      wbs_ack_i = '0;
      wbs_dat_i = '0;
      tick();
      check("t2_ack_one", 32'(wbm_ack_o), 32'd0);

      // ---------------- 3: unmapped slave 3 ----------------
      master_req(32'h0003_0000, 1'b0, 32'h0, 4'hF);
      tick();
      check("t3_stb", 32'(wbs_stb_o), 32'd0);
      check("t3_cyc", 32'(wbs_cyc_o), 32'd0);
      check("t3_err", 32'(wbm_err_o), 32'd1);
      check("t3_ack", 32'(wbm_ack_o), 32'd0);
      check("t3_cnt", 32'(err_count_o), 32'd1);
      master_idle();
      tick();
      check("t3_err_one", 32'(wbm_err_o), 32'd0);
      check("t3_stb_after", 32'(wbs_stb_o), 32'd0);

      // ---------------- 4: watchdog on a silent slave 0 ----------------
      stb_cycles = 0;
      to_pulses  = 0;
      err_cycles = 0;
      ack_cycles = 0;
      master_req(32'h0000_0020, 1'b0, 32'h0, 4'hF);
      tick();
      for (int i = 0; i < 24; i++) begin
         if (wbs_stb_o[0]) stb_cycles++;
         if (timeout_o) to_pulses++;
         if (wbm_ack_o) ack_cycles++;
         if (wbm_err_o) begin
            err_cycles++;
            master_idle();
         end
         tick();
      end
      check("t4_stb_cycles", 32'(stb_cycles), 32'd16);
      check("t4_timeout", 32'(to_pulses), 32'd1);
      check("t4_err", 32'(err_cycles), 32'd1);
      check("t4_ack", 32'(ack_cycles), 32'd0);
      check("t4_cnt", 32'(err_count_o), 32'd2);

      // ---------------- 5: ack+err together, spurious responses ----------------
      master_req(32'h0002_0004, 1'b0, 32'h0, 4'hF);
      tick();
      check("t5_stb", 32'(wbs_stb_o), 32'b100);
      wbs_ack_i = 3'b001;
      wbs_err_i = 3'b010;
      tick();
      check("t5_spur_ack", 32'(wbm_ack_o), 32'd0);
      check("t5_spur_err", 32'(wbm_err_o), 32'd0);
      check("t5_still", 32'(wbs_stb_o), 32'b100);
      wbs_ack_i = 3'b100;
      wbs_err_i = 3'b100;
      wbs_dat_i[95:64] = 32'hCAFE_F00D;
      tick();
      check("t5_err", 32'(wbm_err_o), 32'd1);
      check("t5_ack", 32'(wbm_ack_o), 32'd0);
      check("t5_dat", wbm_dat_o, 32'd0);
      check("t5_cnt", 32'(err_count_o), 32'd3);
      master_idle();
      wbs_ack_i = '0;
      wbs_err_i = '0;
      wbs_dat_i = '0;
      tick();
      // responses while idle are ignored
      wbs_ack_i = 3'b111;
      wbs_err_i = 3'b111;
      tick();
      check("t5_idle_ack", 32'(wbm_ack_o), 32'd0);
      check("t5_idle_err", 32'(wbm_err_o), 32'd0);
      wbs_ack_i = '0;
      wbs_err_i = '0;
      tick();

      // ---------------- 6a: master abort ----------------
      master_req(32'h0001_0000, 1'b0, 32'h0, 4'hF);
      tick();
      check("t6a_stb", 32'(wbs_stb_o), 32'b010);
      master_idle();
      tick();
      check("t6a_stb_off", 32'(wbs_stb_o), 32'd0);
      check("t6a_cyc_off", 32'(wbs_cyc_o), 32'd0);
      ack_cycles = 0;
      err_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (wbm_ack_o) ack_cycles++;
         if (wbm_err_o) err_cycles++;
         tick();
      end
      check("t6a_noack", 32'(ack_cycles), 32'd0);
      check("t6a_noerr", 32'(err_cycles), 32'd0);
      check("t6a_cnt", 32'(err_count_o), 32'd3);

      // ---------------- 6b: reset mid-ACTIVE ----------------
      master_req(32'h0001_0004, 1'b1, 32'h5555_AAAA, 4'hF);
      tick();
      check("t6b_stb", 32'(wbs_stb_o), 32'b010);
      wb_rst_i = 1'b1;
      #1;
      check("t6b_async_stb", 32'(wbs_stb_o), 32'd0);
      check("t6b_async_adr", wbs_adr_o, 32'd0);
      check("t6b_async_cnt", 32'(err_count_o), 32'd0);
      master_idle();
      tick();
      wb_rst_i = 1'b0;
      tick();
      check("t6b_ack", 32'(wbm_ack_o), 32'd0);
      check("t6b_err", 32'(wbm_err_o), 32'd0);
      check("t6b_stb_after", 32'(wbs_stb_o), 32'd0);

      // ---------------- 6c: err counter saturation ----------------
      err_seen = 0;
      for (int i = 0; i < 260; i++) begin
         master_req(32'h0003_0100, 1'b0, 32'h0, 4'hF);
         tick();
         if (wbm_err_o) err_seen++;
         master_idle();
         tick();
         if (i == 253) check("t6c_cnt_254", 32'(err_count_o), 32'hFE);
         if (i == 254) check("t6c_cnt_255", 32'(err_count_o), 32'hFF);
      end
      check("t6c_err_pulses", 32'(err_seen), 32'd260);
      check("t6c_cnt_sat", 32'(err_count_o), 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
